// File: rtl/sm_regdump_pkg.sv
// Shared constants for the debug register dump reader: FSM state encodings
// and the default frame-start marker.
package sm_regdump_pkg;

  localparam logic [1:0] RD_IDLE = 2'd0;
  localparam logic [1:0] RD_HDR  = 2'd1;
  localparam logic [1:0] RD_LOAD = 2'd2;
  localparam logic [1:0] RD_SEND = 2'd3;

  localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;

  localparam int MAX_REG = 31;

endpackage

// File: rtl/sm_word_serializer.sv
// Turns a loaded 32-bit word (MSB first) or a single loaded byte into an
// 8-bit valid/ready stream, flagging the transfer that finishes each item.
module sm_word_serializer
  import sm_regdump_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        loadWord,
  input  logic [31:0] wordIn,
  input  logic        loadByte,
  input  logic [7:0]  byteIn,
  input  logic        outReady,
  output logic [7:0]  outData,
  output logic        outValid,
  output logic        wordDone,
  output logic        byteDone
);

  logic [23:0] rest;
  logic [1:0]  byteCnt;
  logic        single;
  logic        xfer;

  assign xfer     = outValid && outReady;
  assign wordDone = xfer && !single && (byteCnt == 2'd3);
  assign byteDone = xfer && single;

  // outData is its own register so the stream byte never passes through a
  // mux after the flop; while stalled nothing below changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outData  <= 8'h00;
      outValid <= 1'b0;
      rest     <= 24'h0;
      byteCnt  <= 2'd0;
      single   <= 1'b0;
    end else if (loadWord) begin
      outData  <= wordIn[31:24];
      rest     <= wordIn[23:0];
      byteCnt  <= 2'd0;
      single   <= 1'b0;
      outValid <= 1'b1;
    end else if (loadByte) begin
      outData  <= byteIn;
      byteCnt  <= 2'd0;
      single   <= 1'b1;
      outValid <= 1'b1;
    end else if (xfer) begin
      if (single || byteCnt == 2'd3) begin
        outValid <= 1'b0;
      end else begin
        outData <= rest[23:16];
        rest    <= {rest[15:0], 8'h00};
        byteCnt <= byteCnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/sm_regdump.sv
// Debug register dump reader: walks regAddr across the register range and
// streams each word out big-endian, optionally preceded by a marker byte.
module sm_regdump
  import sm_regdump_pkg::*;
#(
  parameter int         FIRST_REG   = 0,
  parameter int         LAST_REG    = 31,
  parameter int         HEADER_EN   = 1,
  parameter logic [7:0] HEADER_BYTE = DEFAULT_HEADER_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic [7:0]  outData,
  output logic        outValid,
  input  logic        outReady,
  output logic        busy,
  output logic        done
);

  if (FIRST_REG < 0 || LAST_REG > MAX_REG || FIRST_REG > LAST_REG) begin : gBadRange
    $error("sm_regdump: illegal register range %0d..%0d", FIRST_REG, LAST_REG);
  end

  localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
  localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);

  logic [1:0] state;
  logic [1:0] nextState;
  logic       loadWord;
  logic       loadByte;
  logic       wordDone;
  logic       byteDone;
  logic       lastWordDone;

  assign lastWordDone = (state == RD_SEND) && wordDone && (regAddr == LAST_ADDR);

  // The done cycle already reads IDLE, so start is masked by done to keep a
  // request landing on the done pulse from launching a second frame.
  always_comb begin
    nextState = state;
    loadWord  = 1'b0;
    loadByte  = 1'b0;
    case (state)
      RD_IDLE: begin
        if (start && !done) begin
          if (HEADER_EN != 0) begin
            nextState = RD_HDR;
            loadByte  = 1'b1;
          end else begin
            nextState = RD_LOAD;
          end
        end
      end
      RD_HDR: begin
        if (byteDone) nextState = RD_LOAD;
      end
      RD_LOAD: begin
        loadWord  = 1'b1;
        nextState = RD_SEND;
      end
      RD_SEND: begin
        if (wordDone) nextState = (regAddr == LAST_ADDR) ? RD_IDLE : RD_LOAD;
      end
      default: nextState = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RD_IDLE;
      regAddr <= FIRST_ADDR;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= nextState;
      busy  <= (nextState != RD_IDLE);
      done  <= lastWordDone;
      if (state == RD_SEND && wordDone) begin
        regAddr <= (regAddr == LAST_ADDR) ? FIRST_ADDR : regAddr + 5'd1;
      end
    end
  end

  sm_word_serializer uSerializer (
    .clk      (clk),
    .rst      (rst),
    .loadWord (loadWord),
    .wordIn   (regData),
    .loadByte (loadByte),
    .byteIn   (HEADER_BYTE),
    .outReady (outReady),
    .outData  (outData),
    .outValid (outValid),
    .wordDone (wordDone),
    .byteDone (byteDone)
  );

endmodule

// File: tb/tb_sm_regdump.sv
// Directed bench for sm_regdump: a default-range instance and a single-register
// headerless instance, both reading a bench-owned register file.
`timescale 1ns/1ps
module tb_sm_regdump;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        outReady = 1'b0;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic [7:0]  outData;
  logic        outValid, busy, done;

  logic        start2 = 1'b0;
  logic        outReady2 = 1'b0;
  logic [4:0]  regAddr2;
  logic [31:0] regData2;
  logic [7:0]  outData2;
  logic        outValid2, busy2, done2;

  logic [31:0] regs [32];
  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign regData  = regs[regAddr];
  assign regData2 = regs[regAddr2];

  sm_regdump dut (
    .clk(clk), .rst(rst), .start(start), .regAddr(regAddr), .regData(regData),
    .outData(outData), .outValid(outValid), .outReady(outReady), .busy(busy), .done(done)
  );

  sm_regdump #(.FIRST_REG(3), .LAST_REG(3), .HEADER_EN(0)) dutSingle (
    .clk(clk), .rst(rst), .start(start2), .regAddr(regAddr2), .regData(regData2),
    .outData(outData2), .outValid(outValid2), .outReady(outReady2), .busy(busy2), .done(done2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  logic [7:0] got [$];
  logic [7:0] got2 [$];
  int doneCnt = 0, doneCyc = -1, busyAtDone = -1, firstValidCyc = -1, startCyc = 0;
  int doneCnt2 = 0, doneCyc2 = -1, startCyc2 = 0, addrDrift = 0;
  logic prevStall = 1'b0;
  logic [7:0] prevData = 8'h00;

  // Sampled mid-cycle: a byte is recorded when it will transfer on the next edge.
  always @(negedge clk) begin
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stallValid", {31'b0, outValid}, 32'd1);
        checkOutput("stallData", {24'b0, outData}, {24'b0, prevData});
      end
      prevStall = outValid && !outReady;
      prevData  = outData;
      if (outValid && outReady) got.push_back(outData);
      if (outValid && firstValidCyc < 0) firstValidCyc = cyc;
      if (done) begin
        doneCnt++;
        doneCyc = cyc;
        busyAtDone = int'(busy);
      end
      if (outValid2 && outReady2) got2.push_back(outData2);
      if (busy2 && regAddr2 != 5'd3) addrDrift++;
      if (done2) begin
        doneCnt2++;
        doneCyc2 = cyc;
      end
    end
  end

  function automatic logic [7:0] gotAt(input int i);
    return (i < got.size()) ? got[i] : 8'h00;
  endfunction

  function automatic int frameErrors(input bit withHdr);
    logic [7:0] exp [$];
    int errs;
    if (withHdr) exp.push_back(8'hA5);
    for (int r = 0; r < 32; r++)
      for (int b = 3; b >= 0; b--) exp.push_back(regs[r][8*b +: 8]);
    errs = (got.size() == exp.size()) ? 0 : 1000;
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      if (got[i] !== exp[i]) errs++;
    return errs;
  endfunction

  // One frame on the default instance; optional random backpressure, a
  // mid-frame start poke, a start in the done cycle, and a mid-frame r2 write.
  task automatic applyStimulus(input bit randReady, input int pokeAt, input bit pokeDone, input int patchAt);
    int n = 0;
    bit seenDone = 0;
    bit patched = 0;
    got.delete();
    doneCnt = 0; doneCyc = -1; busyAtDone = -1; firstValidCyc = -1;
    @(posedge clk); #1;
    outReady = 1'b1; start = 1'b1; startCyc = cyc;
    while (!seenDone && n < 2000) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (randReady) outReady = 1'($urandom_range(0, 1));
      if (n == pokeAt) start = 1'b1;
      if (!patched && patchAt > 0 && got.size() >= patchAt) begin
        regs[2] = 32'hCAFEF00D;
        patched = 1;
      end
      if (done) seenDone = 1;
    end
    checkOutput("doneSeen", {31'b0, seenDone}, 32'd1);
    if (pokeDone) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    outReady = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = {8'(i), 8'(i + 8'h40), 8'(i + 8'h80), 8'(i + 8'hC0)};
    regs[0]  = 32'h0000_0005;
    regs[1]  = 32'h1122_3344;
    regs[31] = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstValid", {31'b0, outValid}, 32'd0);
    checkOutput("rstData", {24'b0, outData}, 32'd0);
    checkOutput("rstBusy", {31'b0, busy}, 32'd0);
    checkOutput("rstDone", {31'b0, done}, 32'd0);
    checkOutput("rstAddr", {27'b0, regAddr}, 32'd0);
    checkOutput("rstAddr2", {27'b0, regAddr2}, 32'd3);
    #2 rst = 1'b0;

    applyStimulus(0, 0, 0, 0);
    checkOutput("t1Count", got.size(), 32'd129);
    checkOutput("t1Hdr", {24'b0, gotAt(0)}, 32'hA5);
    checkOutput("t1Pc", {gotAt(1), gotAt(2), gotAt(3), gotAt(4)}, 32'h0000_0005);
    checkOutput("t1R1", {gotAt(5), gotAt(6), gotAt(7), gotAt(8)}, 32'h1122_3344);
    checkOutput("t1R31", {gotAt(125), gotAt(126), gotAt(127), gotAt(128)}, 32'hDEAD_BEEF);
    checkOutput("t1FirstValid", firstValidCyc - startCyc, 32'd1);
    checkOutput("t1DoneCycle", doneCyc - startCyc, 32'd162);
    checkOutput("t1BusyAtDone", busyAtDone, 32'd0);
    checkOutput("t1DoneCnt", doneCnt, 32'd1);
    checkOutput("t1Frame", frameErrors(1), 32'd0);

    applyStimulus(1, 0, 0, 0);
    checkOutput("t2Frame", frameErrors(1), 32'd0);
    checkOutput("t2DoneCnt", doneCnt, 32'd1);

    regs[3] = 32'h0000_00FF;
    got2.delete(); doneCnt2 = 0; addrDrift = 0;
    @(posedge clk); #1;
    outReady2 = 1'b1; start2 = 1'b1; startCyc2 = cyc;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("t3Count", got2.size(), 32'd4);
    checkOutput("t3Word", {got2.size() > 0 ? got2[0] : 8'h11, got2.size() > 1 ? got2[1] : 8'h11,
                           got2.size() > 2 ? got2[2] : 8'h11, got2.size() > 3 ? got2[3] : 8'h11}, 32'h0000_00FF);
    checkOutput("t3AddrDrift", addrDrift, 32'd0);
    checkOutput("t3DoneCnt", doneCnt2, 32'd1);
    checkOutput("t3DoneCycle", doneCyc2 - startCyc2, 32'd6);
    checkOutput("t3Addr", {27'b0, regAddr2}, 32'd3);

    applyStimulus(0, 40, 1, 0);
    checkOutput("t4Count", got.size(), 32'd129);
    checkOutput("t4DoneCnt", doneCnt, 32'd1);
    checkOutput("t4Busy", {31'b0, busy}, 32'd0);
    checkOutput("t4Frame", frameErrors(1), 32'd0);

    got.delete();
    @(posedge clk); #1;
    outReady = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 100 && got.size() < 10; k++) @(posedge clk);
    checkOutput("t5Reach10", {31'b0, got.size() >= 10}, 32'd1);
    #3 rst = 1'b1;
    #1;
    checkOutput("t5Valid", {31'b0, outValid}, 32'd0);
    checkOutput("t5Busy", {31'b0, busy}, 32'd0);
    checkOutput("t5Addr", {27'b0, regAddr}, 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0);
    checkOutput("t5Hdr", {24'b0, gotAt(0)}, 32'hA5);
    checkOutput("t5Frame", frameErrors(1), 32'd0);

    regs[2] = 32'h2222_2222;
    applyStimulus(0, 0, 0, 6);
    checkOutput("t6R2", {gotAt(9), gotAt(10), gotAt(11), gotAt(12)}, 32'hCAFE_F00D);
    checkOutput("t6Frame", frameErrors(1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
